// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one fifo write port among NUM_REQ
// stream producers. A grant lasts for one packet or MAX_BURST beats, whichever
// ends first. Each written word is tagged with the producer index in its upper bits.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 16,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          fifo_wr,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data,
    input  logic                          fifo_full,
    output logic                          grant_vld,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int                   CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [ID_WIDTH-1:0]                 ptr;
    logic [CNT_WIDTH-1:0]                beat_cnt;
    logic                                any_req;
    logic [ID_WIDTH-1:0]                 winner;
    logic [ID_WIDTH-1:0]                 idx;
    logic                                beat;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  slots;

    assign slots = s_data;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && s_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // State register plus grant bookkeeping (holder, rr pointer, beat count).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant_id <= winner;
                ptr      <= winner;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Next state: arbitrate for one cycle, then hold until packet end or burst cap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (beat && (s_last[grant_id] || beat_cnt == LAST_CNT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: only the holder sees ready, and only while the fifo has room.
    always_comb begin
        s_ready   = '0;
        fifo_wr   = 1'b0;
        grant_vld = 1'b0;
        beat      = 1'b0;
        fifo_data = {grant_id, slots[grant_id]};
        if (state == GRANT) begin
            grant_vld         = 1'b1;
            s_ready[grant_id] = !fifo_full;
            fifo_wr           = s_valid[grant_id] && !fifo_full;
            beat              = s_valid[grant_id] && !fifo_full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=16).
// Requester i presents payload {i, pay[27:0]} so the tag and slot can be cross-checked.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   s_valid;
    logic [127:0] s_data;
    logic [3:0]   s_last;
    logic [3:0]   s_ready;
    logic         fifo_wr;
    logic [33:0]  fifo_data;
    logic         fifo_full;
    logic         grant_vld;
    logic [1:0]   grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] pay;
        logic        gv;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic        wr;
        logic [33:0] fd;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and let outputs settle.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [31:0] pay);
        @(negedge clk);
        reset     = r;
        s_valid   = v;
        s_last    = l;
        fifo_full = f;
        s_data    = {32'h3000_0000 | pay, 32'h2000_0000 | pay, 32'h1000_0000 | pay, pay};
        #1;
    endtask

    task automatic check_outs(input string tag, input logic gv, input logic [1:0] gid,
                              input logic [3:0] rdy, input logic wr, input logic [33:0] fd);
        chk({tag, ".grant_vld"}, 64'(grant_vld), 64'(gv));
        chk({tag, ".grant_id"},  64'(grant_id),  64'(gid));
        chk({tag, ".s_ready"},   64'(s_ready),   64'(rdy));
        chk({tag, ".fifo_wr"},   64'(fifo_wr),   64'(wr));
        if (wr) chk({tag, ".fifo_data"}, 64'(fifo_data), 64'(fd));
    endtask

    function automatic void add(input string n, input logic r, input logic [3:0] v,
                                input logic [3:0] l, input logic f, input logic [31:0] p,
                                input logic gv, input logic [1:0] gid, input logic [3:0] rdy,
                                input logic wr, input logic [33:0] fd);
        vec_t e;
        e.name = n; e.rst = r; e.valid = v; e.last = l; e.full = f; e.pay = p;
        e.gv = gv; e.gid = gid; e.rdy = rdy; e.wr = wr; e.fd = fd;
        vt.push_back(e);
    endfunction

    initial begin
        reset = 1'b1; s_valid = '0; s_last = '0; fifo_full = 1'b0; s_data = '0;

        //   name        rst valid    last     full pay        gv id    ready    wr fifo_data
        add("reset",     1, 4'b1111, 4'b0000, 0, 32'h0,     0, 2'd0, 4'b0000, 0, 34'h0);
        // three-beat packet from requester 0
        add("t1_arb",    0, 4'b0001, 4'b0000, 0, 32'hA,     0, 2'd0, 4'b0000, 0, 34'h0);
        add("t1_b0",     0, 4'b0001, 4'b0000, 0, 32'hA,     1, 2'd0, 4'b0001, 1, 34'h0_0000000A);
        add("t1_b1",     0, 4'b0001, 4'b0000, 0, 32'hB,     1, 2'd0, 4'b0001, 1, 34'h0_0000000B);
        add("t1_b2",     0, 4'b0001, 4'b0001, 0, 32'hC,     1, 2'd0, 4'b0001, 1, 34'h0_0000000C);
        add("t1_rel",    0, 4'b0000, 4'b0000, 0, 32'h0,     0, 2'd0, 4'b0000, 0, 34'h0);
        // move pointer to 1, then 1 and 3 contend: 3 goes first
        add("t6_arb1",   0, 4'b0010, 4'b0000, 0, 32'h11,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("t6_g1",     0, 4'b0010, 4'b0010, 0, 32'h11,    1, 2'd1, 4'b0010, 1, 34'h1_10000011);
        add("t6_arb",    0, 4'b1010, 4'b1111, 0, 32'h33,    0, 2'd1, 4'b0000, 0, 34'h0);
        add("t6_g3",     0, 4'b1010, 4'b1111, 0, 32'h33,    1, 2'd3, 4'b1000, 1, 34'h3_30000033);
        add("t6_bub",    0, 4'b0010, 4'b0010, 0, 32'h11,    0, 2'd3, 4'b0000, 0, 34'h0);
        add("t6_g1b",    0, 4'b0010, 4'b0010, 0, 32'h11,    1, 2'd1, 4'b0010, 1, 34'h1_10000011);
        add("rst_idle",  1, 4'b0000, 4'b0000, 0, 32'h0,     0, 2'd1, 4'b0000, 0, 34'h0);
        add("rst_chk",   0, 4'b0000, 4'b0000, 0, 32'h0,     0, 2'd0, 4'b0000, 0, 34'h0);
        // all four requesting single-beat packets: 0,1,2,3,0,1 with bubbles
        add("t2_a0",     0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("t2_g0",     0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd0, 4'b0001, 1, 34'h0_00000044);
        add("t2_a1",     0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("t2_g1",     0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd1, 4'b0010, 1, 34'h1_10000044);
        add("t2_a2",     0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd1, 4'b0000, 0, 34'h0);
        add("t2_g2",     0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd2, 4'b0100, 1, 34'h2_20000044);
        add("t2_a3",     0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd2, 4'b0000, 0, 34'h0);
        add("t2_g3",     0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd3, 4'b1000, 1, 34'h3_30000044);
        add("t2_a0b",    0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd3, 4'b0000, 0, 34'h0);
        add("t2_g0b",    0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd0, 4'b0001, 1, 34'h0_00000044);
        add("t2_a1b",    0, 4'b1111, 4'b1111, 0, 32'h44,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("t2_g1b",    0, 4'b1111, 4'b1111, 0, 32'h44,    1, 2'd1, 4'b0010, 1, 34'h1_10000044);
        // reset in the middle of requester 0's packet; 0 wins again afterwards
        add("t5_arb",    0, 4'b0011, 4'b0000, 0, 32'h55,    0, 2'd1, 4'b0000, 0, 34'h0);
        add("t5_b0",     0, 4'b0011, 4'b0000, 0, 32'h55,    1, 2'd0, 4'b0001, 1, 34'h0_00000055);
        add("t5_b1rst",  1, 4'b0011, 4'b0000, 0, 32'h56,    1, 2'd0, 4'b0001, 1, 34'h0_00000056);
        add("t5_after",  0, 4'b0011, 4'b0000, 0, 32'h57,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("t5_g0",     0, 4'b0011, 4'b0000, 0, 32'h57,    1, 2'd0, 4'b0001, 1, 34'h0_00000057);
        add("t5_last",   0, 4'b0011, 4'b0001, 0, 32'h58,    1, 2'd0, 4'b0001, 1, 34'h0_00000058);
        add("t5_rel",    0, 4'b0000, 4'b0000, 0, 32'h0,     0, 2'd0, 4'b0000, 0, 34'h0);
        // holder drops valid (last without valid ignored), others wait, full stalls
        add("hold_arb",  0, 4'b0001, 4'b0000, 0, 32'h60,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("hold_b0",   0, 4'b0001, 4'b0000, 0, 32'h60,    1, 2'd0, 4'b0001, 1, 34'h0_00000060);
        add("hold_nov",  0, 4'b0000, 4'b0001, 0, 32'h61,    1, 2'd0, 4'b0001, 0, 34'h0);
        add("hold_oth",  0, 4'b0100, 4'b0000, 0, 32'h61,    1, 2'd0, 4'b0001, 0, 34'h0);
        add("hold_full", 0, 4'b0001, 4'b0000, 1, 32'h61,    1, 2'd0, 4'b0000, 0, 34'h0);
        add("hold_last", 0, 4'b0001, 4'b0001, 0, 32'h61,    1, 2'd0, 4'b0001, 1, 34'h0_00000061);
        add("hold_a2",   0, 4'b0100, 4'b0000, 0, 32'h62,    0, 2'd0, 4'b0000, 0, 34'h0);
        add("hold_g2",   0, 4'b0100, 4'b0100, 0, 32'h62,    1, 2'd2, 4'b0100, 1, 34'h2_20000062);
        add("hold_rel",  0, 4'b0000, 4'b0000, 0, 32'h0,     0, 2'd2, 4'b0000, 0, 34'h0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].valid, vt[i].last, vt[i].full, vt[i].pay);
            check_outs($sformatf("%s[%0d]", vt[i].name, i),
                       vt[i].gv, vt[i].gid, vt[i].rdy, vt[i].wr, vt[i].fd);
        end

        // 20-beat packet from requester 2 split by the 16-beat cap; 3 and 0 go in between
        drive(0, 4'b0100, 4'b0000, 0, 32'h100);
        check_outs("t3_arb", 0, 2'd2, 4'b0000, 0, 34'h0);
        for (int k = 0; k < 16; k++) begin
            drive(0, 4'b1101, 4'b1001, 0, 32'h100 + 32'(k));
            check_outs($sformatf("t3_beat%0d", k), 1, 2'd2, 4'b0100, 1,
                       {2'd2, 32'h2000_0100 + 32'(k)});
        end
        drive(0, 4'b1101, 4'b1001, 0, 32'h110);
        check_outs("t3_bub1", 0, 2'd2, 4'b0000, 0, 34'h0);
        drive(0, 4'b1101, 4'b1001, 0, 32'h110);
        check_outs("t3_g3", 1, 2'd3, 4'b1000, 1, {2'd3, 32'h3000_0110});
        drive(0, 4'b0101, 4'b0001, 0, 32'h110);
        check_outs("t3_bub2", 0, 2'd3, 4'b0000, 0, 34'h0);
        drive(0, 4'b0101, 4'b0001, 0, 32'h110);
        check_outs("t3_g0", 1, 2'd0, 4'b0001, 1, {2'd0, 32'h0000_0110});
        drive(0, 4'b0100, 4'b0000, 0, 32'h110);
        check_outs("t3_bub3", 0, 2'd0, 4'b0000, 0, 34'h0);
        for (int k = 16; k < 20; k++) begin
            drive(0, 4'b0100, (k == 19) ? 4'b0100 : 4'b0000, 0, 32'h100 + 32'(k));
            check_outs($sformatf("t3_beat%0d", k), 1, 2'd2, 4'b0100, 1,
                       {2'd2, 32'h2000_0100 + 32'(k)});
        end
        drive(0, 4'b0000, 4'b0000, 0, 32'h0);
        check_outs("t3_end", 0, 2'd2, 4'b0000, 0, 34'h0);

        // five full cycles mid-burst: stalled beats are neither written nor counted
        drive(0, 4'b0010, 4'b0000, 0, 32'h200);
        check_outs("t4_arb", 0, 2'd2, 4'b0000, 0, 34'h0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b0010, 4'b0000, 0, 32'h200 + 32'(k));
            check_outs($sformatf("t4_beat%0d", k), 1, 2'd1, 4'b0010, 1,
                       {2'd1, 32'h1000_0200 + 32'(k)});
        end
        for (int s = 0; s < 5; s++) begin
            drive(0, 4'b0010, 4'b0000, 1, 32'h205);
            check_outs($sformatf("t4_stall%0d", s), 1, 2'd1, 4'b0000, 0, 34'h0);
        end
        for (int k = 5; k < 16; k++) begin
            drive(0, 4'b0010, 4'b0000, 0, 32'h200 + 32'(k));
            check_outs($sformatf("t4_beat%0d", k), 1, 2'd1, 4'b0010, 1,
                       {2'd1, 32'h1000_0200 + 32'(k)});
        end
        drive(0, 4'b0010, 4'b0000, 0, 32'h210);
        check_outs("t4_cap", 0, 2'd1, 4'b0000, 0, 34'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
